// File: rtl/seq_det_sched.sv
// Round-robin arbiter that time-shares one overlapping serial pattern matcher
// among NREQ bit-stream requesters, one FRAME_LEN-bit frame per grant.
module seq_det_sched #(
  parameter int              NREQ      = 4,
  parameter int              PAT_W     = 6,
  parameter logic [PAT_W-1:0] PATTERN  = 6'b111010,
  parameter int              FRAME_LEN = 16,
  parameter int              CNT_W     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           bit_in,
  output logic [NREQ-1:0]           grant,
  output logic                      busy,
  output logic                      det_out,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [CNT_W-1:0]          match_cnt
);

  localparam int ID_W = $clog2(NREQ);
  localparam int BC_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt, arb_sel;
  logic              arb_found;
  logic [PAT_W-1:0]  shreg, shreg_nxt, shift_val;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt, cnt_inc;
  logic [NREQ-1:0]   grant_nxt;
  logic              busy_nxt, det_nxt, done_nxt;
  logic [ID_W-1:0]   done_id_nxt;
  logic [CNT_W-1:0]  match_nxt;

  // ptr doubles as the selected channel for the frame in progress
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    grant_nxt   = grant;
    busy_nxt    = busy;
    det_nxt     = 1'b0;
    done_nxt    = 1'b0;
    done_id_nxt = done_id;
    match_nxt   = match_cnt;
    arb_found   = 1'b0;
    arb_sel     = '0;
    shift_val   = {shreg[PAT_W-2:0], bit_in[ptr]};
    cnt_inc     = bit_cnt + BC_W'(1);

    // first requester after the last one served, wrapping
    for (int i = 1; i <= NREQ; i++) begin
      if (!arb_found && req[ID_W'((int'(ptr) + i) % NREQ)]) begin
        arb_found = 1'b1;
        arb_sel   = ID_W'((int'(ptr) + i) % NREQ);
      end
    end

    case (state)
      IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (arb_found) begin
          state_nxt   = RUN;
          ptr_nxt     = arb_sel;
          grant_nxt   = NREQ'(1) << arb_sel;
          busy_nxt    = 1'b1;
          bit_cnt_nxt = '0;
          shreg_nxt   = '0;
          match_nxt   = '0;
        end
      end
      RUN: begin
        if (!req[ptr]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          match_nxt = '0;
        end else begin
          shreg_nxt   = shift_val;
          bit_cnt_nxt = cnt_inc;
          if (shift_val == PATTERN && cnt_inc >= BC_W'(PAT_W)) begin
            det_nxt = 1'b1;
            if (match_cnt != '1) match_nxt = match_cnt + CNT_W'(1);
          end
          if (cnt_inc == BC_W'(FRAME_LEN)) begin
            state_nxt   = DONE;
            grant_nxt   = '0;
            done_nxt    = 1'b1;
            done_id_nxt = ptr;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= ID_W'(NREQ - 1);
      shreg     <= '0;
      bit_cnt   <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      det_out   <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      grant     <= grant_nxt;
      busy      <= busy_nxt;
      det_out   <= det_nxt;
      done      <= done_nxt;
      done_id   <= done_id_nxt;
      match_cnt <= match_nxt;
    end
  end

endmodule
